mbist_march_ctrl: RTL
=====================

// Module: mbist_march_ctrl
// PURPOSE
//  Parametrised March-algorithm memory BIST controller sitting between a functional
//  port and one synchronous single-port RAM. It muxes the RAM to the BIST engine during test.
//  Runs MATS+ or March C- with a solid or checkerboard data background.
//  Logs the first failing address and syndrome, and counts all failing reads.
// PARAMETERS
//  SIZE    6  address width; N = 2**SIZE words
//  LENGTH  8  data word width
//  FCNT_W  8  width of the saturating fail counter
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin test (sampled only in IDLE/DONE)
//  alg        in   1       0 = MATS+ (K=5), 1 = March C- (K=10); sampled with start
//  bg_sel     in   1       0 = solid (B = 0), 1 = checkerboard (B bit i = i[0], 0xAA for 8); sampled with start
//  csin       in   1       functional chip select
//  rwbarin    in   1       functional 1 = read, 0 = write
//  address    in   SIZE    functional address
//  datain     in   LENGTH  functional write data
//  dataout    out  LENGTH  functional read data
//  mem_cs     out  1       RAM chip select
//  mem_rwbar  out  1       RAM read/write-bar
//  mem_addr   out  SIZE    RAM address
//  mem_wdata  out  LENGTH  RAM write data
//  mem_rdata  in   LENGTH  RAM read data, valid 1 cycle after read issue
//  busy       out  1       test running
//  done       out  1       test finished; held until next start or rst
//  fail       out  1       sticky; any read mismatch in the current run
//  fail_addr  out  SIZE    address of the first mismatch
//  fail_data  out  LENGTH  first syndrome = mem_rdata ^ expected
//  fail_count out  FCNT_W  mismatch count; saturates at all-ones
// BEHAVIOUR
//  Reset values: state = IDLE; busy, done, fail = 0; fail_addr, fail_data, fail_count = 0;
//    compare pipeline cleared.
//  Bypass mode (IDLE/DONE):
//    - mem_cs/rwbar/addr/wdata = csin/rwbarin/address/datain, combinational.
//    - dataout = mem_rdata.
//  BUSY mode:
//    - The engine drives the RAM; functional inputs are ignored; dataout = 0.
//  Patterns: w0/r0 use B; w1/r1 use ~B.
//    - up order addresses 0..N-1; down order addresses N-1..0; either order = up.
//  MATS+ sequence: {w0} ; up{r0,w1} ; down{r1,w0}.
//  March C- sequence: {w0} ; up{r0,w1} ; up{r1,w0} ; down{r0,w1} ; down{r1,w0} ; {r0}.
//  FSM: IDLE -> RUN -> DRAIN -> DONE.
//    - IDLE/DONE + start=1 -> RUN: clear done, fail, fail_addr, fail_data, fail_count.
//    - RUN issues one op per cycle: all ops of an element on one address, then the next
//      address. The element ends at its last address; then the next element begins.
//    - The address counter is SIZE bits. Terminal address is detected explicitly; never rely on wrap.
//    - After the final op of the final element -> DRAIN (1 cycle, final compare) -> DONE.
//    - done rises and busy falls on posedge K*N+1 after the start-sampling edge.
//  Compare pipeline:
//    - A read issued in cycle t registers its expected value, address and valid flag.
//    - mem_rdata is compared in cycle t+1.
//    - On mismatch: fail <= 1 and fail_count++ (saturating).
//    - fail_addr and fail_data load only on the first mismatch of the run.
//  Boundary rules:
//    - start while busy is ignored.
//    - alg/bg_sel changes mid-run have no effect.
//    - rst mid-run returns to IDLE next edge; bypass is restored and the in-flight compare is discarded.
//    - A mismatch in DRAIN counts normally.
//    - Fail outputs stay valid in DONE until the next start.
// TESTING
//  1. rst=1 for 2 clk -> busy=0, done=0, fail=0, fail_count=0; then functional write of 10
//     to addr 0 and read back -> dataout=10.
//  2. Fault-free RAM, SIZE=6, alg=0, bg_sel=0 -> done on posedge 321; fail=0, count=0;
//     RAM all 0x00.
//  3. Fault-free, alg=1, bg_sel=1 -> done on posedge 641; fail=0; RAM all 8'b10101010;
//     functional read after done -> 0xAA.
//  4. Addr 17 bit 3 stuck-at-1, alg=0, bg_sel=0 -> fail=1, fail_addr=17, fail_data=0x08,
//     fail_count=1.
//     Same fault with alg=1 -> fail_count=3.
//  5. rst pulsed at posedge 100 of a run -> busy=0 next edge, bypass active;
//     restart gives the full-length run.
//  6. start re-pulsed and csin=1 toggled while busy -> no restart; mem_* unaffected;
//     done still on posedge 321.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// March-algorithm memory BIST controller (MATS+ / March C-) placed between a functional
// port and a synchronous single-port RAM; logs first failure and counts failing reads.
module mbist_march_ctrl #(
    parameter int SIZE   = 6,
    parameter int LENGTH = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              alg,
    input  logic              bg_sel,
    input  logic              csin,
    input  logic              rwbarin,
    input  logic [SIZE-1:0]   address,
    input  logic [LENGTH-1:0] datain,
    output logic [LENGTH-1:0] dataout,
    output logic              mem_cs,
    output logic              mem_rwbar,
    output logic [SIZE-1:0]   mem_addr,
    output logic [LENGTH-1:0] mem_wdata,
    input  logic [LENGTH-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [SIZE-1:0]   fail_addr,
    output logic [LENGTH-1:0] fail_data,
    output logic [FCNT_W-1:0] fail_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One march element: up to two ops per address, each op = {read, use ~B}.
    typedef struct packed {
        logic [1:0] nops;
        logic       down;
        logic       rd0;
        logic       inv0;
        logic       rd1;
        logic       inv1;
        logic       last;
    } elem_t;

    localparam logic [SIZE-1:0]   ADDR_MIN = {SIZE{1'b0}};
    localparam logic [SIZE-1:0]   ADDR_MAX = {SIZE{1'b1}};
    localparam logic [FCNT_W-1:0] CNT_MAX  = {FCNT_W{1'b1}};

    function automatic logic [LENGTH-1:0] background(input logic sel);
        logic [LENGTH-1:0] b;
        for (int i = 0; i < LENGTH; i++) begin
            b[i] = sel & (i % 2 == 1);
        end
        return b;
    endfunction

    // Element table, indexed by {alg, element}: fields nops,down,rd0,inv0,rd1,inv1,last
    function automatic elem_t elem_info(input logic a, input logic [2:0] idx);
        elem_t e;
        case ({a, idx})
            4'b0_000: e = {2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // {w0}
            4'b0_001: e = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // up{r0,w1}
            4'b0_010: e = {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // down{r1,w0}
            4'b1_000: e = {2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // {w0}
            4'b1_001: e = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // up{r0,w1}
            4'b1_010: e = {2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // up{r1,w0}
            4'b1_011: e = {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // down{r0,w1}
            4'b1_100: e = {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // down{r1,w0}
            4'b1_101: e = {2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // {r0}
            default:  e = {2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        endcase
        return e;
    endfunction

    state_t            state_r, state_nxt_s;
    logic              alg_r, bg_r;
    logic [2:0]        elem_r;
    logic              op_r;
    logic [SIZE-1:0]   addr_r;
    logic              busy_r, done_r;
    logic              cmp_valid_r;
    logic [LENGTH-1:0] cmp_exp_r;
    logic [SIZE-1:0]   cmp_addr_r;
    logic              fail_r;
    logic [SIZE-1:0]   fail_addr_r;
    logic [LENGTH-1:0] fail_data_r;
    logic [FCNT_W-1:0] fail_count_r;

    elem_t             cur_s, nxt_elem_s;
    logic              cur_rd_s, cur_inv_s, op_last_s, addr_term_s;
    logic [SIZE-1:0]   nxt_start_s;
    logic [LENGTH-1:0] bg_s, eng_wdata_s, syndrome_s;
    logic              start_ok_s, run_end_s;

    // Decode of the current op and the address sequencing conditions
    always_comb begin
        cur_s       = elem_info(alg_r, elem_r);
        nxt_elem_s  = elem_info(alg_r, elem_r + 3'd1);
        cur_rd_s    = op_r ? cur_s.rd1  : cur_s.rd0;
        cur_inv_s   = op_r ? cur_s.inv1 : cur_s.inv0;
        op_last_s   = (cur_s.nops == 2'd1) || op_r;
        addr_term_s = cur_s.down ? (addr_r == ADDR_MIN) : (addr_r == ADDR_MAX);
        nxt_start_s = nxt_elem_s.down ? ADDR_MAX : ADDR_MIN;
        bg_s        = background(bg_r);
        eng_wdata_s = cur_inv_s ? ~bg_s : bg_s;
        syndrome_s  = mem_rdata ^ cmp_exp_r;
        start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
        run_end_s   = op_last_s && addr_term_s && cur_s.last;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) state_nxt_s = S_RUN;
                else       state_nxt_s = state_r;
            end
            S_RUN: begin
                if (run_end_s) state_nxt_s = S_DRAIN;
                else           state_nxt_s = S_RUN;
            end
            S_DRAIN: state_nxt_s = S_DONE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN) || (state_nxt_s == S_DRAIN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Element / op / address sequencing; configuration latched at start
    always_ff @(posedge clk) begin
        if (rst) begin
            alg_r  <= 1'b0;
            bg_r   <= 1'b0;
            elem_r <= 3'd0;
            op_r   <= 1'b0;
            addr_r <= ADDR_MIN;
        end else if (start_ok_s) begin
            alg_r  <= alg;
            bg_r   <= bg_sel;
            elem_r <= 3'd0;
            op_r   <= 1'b0;
            addr_r <= ADDR_MIN;
        end else if (state_r == S_RUN) begin
            if (!op_last_s) begin
                op_r <= 1'b1;
            end else begin
                op_r <= 1'b0;
                if (addr_term_s) begin
                    elem_r <= elem_r + 3'd1;
                    addr_r <= nxt_start_s;
                end else if (cur_s.down) begin
                    addr_r <= addr_r - {{(SIZE-1){1'b0}}, 1'b1};
                end else begin
                    addr_r <= addr_r + {{(SIZE-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            op_r <= op_r;
        end
    end

    // Compare pipeline and failure logging; mem_rdata checked one cycle after the read
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid_r  <= 1'b0;
            cmp_exp_r    <= {LENGTH{1'b0}};
            cmp_addr_r   <= {SIZE{1'b0}};
            fail_r       <= 1'b0;
            fail_addr_r  <= {SIZE{1'b0}};
            fail_data_r  <= {LENGTH{1'b0}};
            fail_count_r <= {FCNT_W{1'b0}};
        end else begin
            cmp_valid_r <= (state_r == S_RUN) && cur_rd_s;
            cmp_exp_r   <= eng_wdata_s;
            cmp_addr_r  <= addr_r;
            if (start_ok_s) begin
                fail_r       <= 1'b0;
                fail_addr_r  <= {SIZE{1'b0}};
                fail_data_r  <= {LENGTH{1'b0}};
                fail_count_r <= {FCNT_W{1'b0}};
            end else if (cmp_valid_r && (syndrome_s != {LENGTH{1'b0}})) begin
                fail_r <= 1'b1;
                if (fail_count_r != CNT_MAX) fail_count_r <= fail_count_r + {{(FCNT_W-1){1'b0}}, 1'b1};
                else                         fail_count_r <= fail_count_r;
                if (!fail_r) begin
                    fail_addr_r <= cmp_addr_r;
                    fail_data_r <= syndrome_s;
                end else begin
                    fail_addr_r <= fail_addr_r;
                end
            end else begin
                fail_r <= fail_r;
            end
        end
    end

    // RAM port mux: engine owns the RAM while running, otherwise functional bypass
    always_comb begin
        mem_cs    = csin;
        mem_rwbar = rwbarin;
        mem_addr  = address;
        mem_wdata = datain;
        dataout   = mem_rdata;
        if ((state_r == S_RUN) || (state_r == S_DRAIN)) begin
            mem_cs    = (state_r == S_RUN);
            mem_rwbar = cur_rd_s;
            mem_addr  = addr_r;
            mem_wdata = eng_wdata_s;
            dataout   = {LENGTH{1'b0}};
        end else begin
            dataout   = mem_rdata;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign fail       = fail_r;
    assign fail_addr  = fail_addr_r;
    assign fail_data  = fail_data_r;
    assign fail_count = fail_count_r;

endmodule
